// File: rtl/inst_pattern_match.sv
// Thumb / Thumb-2 instruction field extractor.
// Purely combinational pattern decode of one 16- or 32-bit instruction,
// followed by a single output register stage (1-cycle latency).
module inst_pattern_match (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst,
    input  logic        carry_in,
    output logic [3:0]  rd,
    output logic [3:0]  rd2,
    output logic [3:0]  ra,
    output logic [3:0]  rb,
    output logic        imm_or_reg,
    output logic        shift_or_not,
    output logic        thumb_or_not,
    output logic [31:0] imm32,
    output logic [11:0] imm12,
    output logic [1:0]  s_type,
    output logic [4:0]  s_offset,
    output logic        index,
    output logic        add,
    output logic        wback,
    output logic        reg_mask
);

    localparam int unsigned REG_W   = 4;
    localparam int unsigned IMM32_W = 32;
    localparam int unsigned IMM12_W = 12;

    typedef struct packed {
        logic [REG_W-1:0]   rd;
        logic [REG_W-1:0]   rd2;
        logic [REG_W-1:0]   ra;
        logic [REG_W-1:0]   rb;
        logic               imm_or_reg;
        logic               shift_or_not;
        logic               thumb_or_not;
        logic [IMM32_W-1:0] imm32;
        logic [IMM12_W-1:0] imm12;
        logic [1:0]         s_type;
        logic [4:0]         s_offset;
        logic               index;
        logic               add;
        logic               wback;
        logic               reg_mask;
    } dec_t;

    logic [15:0]        w_hw1;
    logic [15:0]        w_hw2;
    logic               w_is32;
    logic [11:0]        w_mimm12;
    logic [31:0]        w_rot_src;
    logic [31:0]        w_mimm32;
    dec_t               w_dec;
    dec_t               r_dec;
    logic               w_unused;

    assign w_hw1    = inst[31:16];
    assign w_hw2    = inst[15:0];
    assign w_is32   = (inst[31:27] == 5'b11101) || (inst[31:27] == 5'b11110) ||
                      (inst[31:27] == 5'b11111);
    assign w_mimm12 = {w_hw1[10], w_hw2[14:12], w_hw2[7:0]};
    assign w_rot_src = {24'd0, 1'b1, w_mimm12[6:0]};

    // APSR.C is reserved and the LDM/STM/LDRD load bit is not a decoded field.
    assign w_unused = ^{carry_in, w_hw1[4]};

    // ThumbExpandImm of the modified-immediate field.
    always_comb begin
        w_mimm32 = '0;
        if (w_mimm12[11:10] == 2'b00) begin
            case (w_mimm12[9:8])
                2'b00:   w_mimm32 = {24'd0, w_mimm12[7:0]};
                2'b01:   w_mimm32 = {8'd0, w_mimm12[7:0], 8'd0, w_mimm12[7:0]};
                2'b10:   w_mimm32 = {w_mimm12[7:0], 8'd0, w_mimm12[7:0], 8'd0};
                default: w_mimm32 = {4{w_mimm12[7:0]}};
            endcase
        end else begin
            // Rotation amount is always >= 8 here, so the left shift never reaches 32.
            w_mimm32 = (w_rot_src >> w_mimm12[11:7]) |
                       (w_rot_src << (6'd32 - {1'b0, w_mimm12[11:7]}));
        end
    end

    // Pattern match and field extraction; unmatched encodings leave fields at zero.
    always_comb begin
        w_dec              = '0;
        w_dec.thumb_or_not = ~w_is32;
        if (!w_is32) begin
            if ((w_hw1[15:13] == 3'b000) && (w_hw1[12:11] != 2'b11)) begin
                w_dec.rd           = REG_W'(w_hw1[2:0]);
                w_dec.rb           = REG_W'(w_hw1[5:3]);
                w_dec.s_type       = w_hw1[12:11];
                w_dec.s_offset     = w_hw1[10:6];
                w_dec.shift_or_not = 1'b1;
            end else if (w_hw1[15:11] == 5'b00011) begin
                w_dec.rd = REG_W'(w_hw1[2:0]);
                w_dec.ra = REG_W'(w_hw1[5:3]);
                if (w_hw1[10]) begin
                    w_dec.imm32      = IMM32_W'(w_hw1[8:6]);
                    w_dec.imm_or_reg = 1'b1;
                end else begin
                    w_dec.rb = REG_W'(w_hw1[8:6]);
                end
            end else if (w_hw1[15:13] == 3'b001) begin
                w_dec.rd         = REG_W'(w_hw1[10:8]);
                w_dec.ra         = REG_W'(w_hw1[10:8]);
                w_dec.imm32      = IMM32_W'(w_hw1[7:0]);
                w_dec.imm_or_reg = 1'b1;
            end else if (w_hw1[15:10] == 6'b010000) begin
                w_dec.rd = REG_W'(w_hw1[2:0]);
                w_dec.ra = REG_W'(w_hw1[2:0]);
                w_dec.rb = REG_W'(w_hw1[5:3]);
            end else if (w_hw1[15:13] == 3'b011) begin
                w_dec.rd    = REG_W'(w_hw1[2:0]);
                w_dec.ra    = REG_W'(w_hw1[5:3]);
                // Byte forms use imm5 directly, word forms scale by 4.
                w_dec.imm32 = w_hw1[12] ? IMM32_W'(w_hw1[10:6])
                                        : IMM32_W'({w_hw1[10:6], 2'b00});
                w_dec.index = 1'b1;
                w_dec.add   = 1'b1;
            end else if ((w_hw1[15:12] == 4'b1011) && (w_hw1[10:9] == 2'b10)) begin
                w_dec.ra       = REG_W'(13);
                w_dec.reg_mask = 1'b1;
            end else if (w_hw1[15:12] == 4'b1100) begin
                w_dec.ra       = REG_W'(w_hw1[10:8]);
                w_dec.reg_mask = 1'b1;
            end
        end else begin
            if ((w_hw1[15:11] == 5'b11110) && !w_hw1[9] && !w_hw2[15]) begin
                w_dec.ra         = w_hw1[3:0];
                w_dec.rd         = w_hw2[11:8];
                w_dec.imm12      = w_mimm12;
                w_dec.imm32      = w_mimm32;
                w_dec.imm_or_reg = 1'b1;
            end else if (w_hw1[15:9] == 7'b1110101) begin
                w_dec.ra           = w_hw1[3:0];
                w_dec.rd           = w_hw2[11:8];
                w_dec.rb           = w_hw2[3:0];
                w_dec.s_type       = w_hw2[5:4];
                w_dec.s_offset     = {w_hw2[14:12], w_hw2[7:6]};
                w_dec.shift_or_not = 1'b1;
            end else if ((w_hw1[15:8] == 8'hF8) && w_hw1[7]) begin
                w_dec.rd    = w_hw2[15:12];
                w_dec.ra    = w_hw1[3:0];
                w_dec.imm12 = w_hw2[11:0];
                w_dec.imm32 = IMM32_W'(w_hw2[11:0]);
                w_dec.index = 1'b1;
                w_dec.add   = 1'b1;
            end else if ((w_hw1[15:8] == 8'hF8) && !w_hw1[7] && w_hw2[11]) begin
                w_dec.rd    = w_hw2[15:12];
                w_dec.ra    = w_hw1[3:0];
                w_dec.imm32 = IMM32_W'(w_hw2[7:0]);
                w_dec.index = w_hw2[10];
                w_dec.add   = w_hw2[9];
                w_dec.wback = w_hw2[8];
            end else if ((w_hw1[15:9] == 7'b1110100) && w_hw1[6]) begin
                w_dec.rd    = w_hw2[15:12];
                w_dec.rd2   = w_hw2[11:8];
                w_dec.ra    = w_hw1[3:0];
                w_dec.imm32 = IMM32_W'({w_hw2[7:0], 2'b00});
                w_dec.index = w_hw1[8];
                w_dec.add   = w_hw1[7];
                w_dec.wback = w_hw1[5];
            end else if ((w_hw1[15:9] == 7'b1110100) && !w_hw1[6]) begin
                w_dec.ra       = w_hw1[3:0];
                w_dec.reg_mask = 1'b1;
                w_dec.wback    = w_hw1[5];
            end
        end
    end

    // Output register; reset clears every field.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dec <= '0;
        end else begin
            r_dec <= w_dec;
        end
    end

    assign rd           = r_dec.rd;
    assign rd2          = r_dec.rd2;
    assign ra           = r_dec.ra;
    assign rb           = r_dec.rb;
    assign imm_or_reg   = r_dec.imm_or_reg;
    assign shift_or_not = r_dec.shift_or_not;
    assign thumb_or_not = r_dec.thumb_or_not;
    assign imm32        = r_dec.imm32;
    assign imm12        = r_dec.imm12;
    assign s_type       = r_dec.s_type;
    assign s_offset     = r_dec.s_offset;
    assign index        = r_dec.index;
    assign add          = r_dec.add;
    assign wback        = r_dec.wback;
    assign reg_mask     = r_dec.reg_mask;

endmodule

// File: tb/tb_inst_pattern_match.sv
// Table-driven bench for inst_pattern_match with a scoreboard queue.
module tb_inst_pattern_match;

    typedef struct packed {
        logic [3:0]  rd;
        logic [3:0]  rd2;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic        imm_or_reg;
        logic        shift_or_not;
        logic        thumb_or_not;
        logic [31:0] imm32;
        logic [11:0] imm12;
        logic [1:0]  s_type;
        logic [4:0]  s_offset;
        logic        index;
        logic        add;
        logic        wback;
        logic        reg_mask;
    } out_t;

    typedef struct {
        logic [31:0] inst;
        out_t        exp;
    } vec_t;

    typedef struct {
        out_t exp;
        int   id;
    } sb_t;

    localparam int NV = 26;

    logic        clk;
    logic        rst;
    logic [31:0] inst;
    logic        carry_in;
    logic [3:0]  rd, rd2, ra, rb;
    logic        imm_or_reg, shift_or_not, thumb_or_not;
    logic [31:0] imm32;
    logic [11:0] imm12;
    logic [1:0]  s_type;
    logic [4:0]  s_offset;
    logic        index, add, wback, reg_mask;

    vec_t vecs [NV];
    sb_t  sb_q [$];
    int   n_cmp = 0;
    int   n_bad = 0;
    out_t zero_o;

    inst_pattern_match dut (
        .clk(clk), .rst(rst), .inst(inst), .carry_in(carry_in),
        .rd(rd), .rd2(rd2), .ra(ra), .rb(rb),
        .imm_or_reg(imm_or_reg), .shift_or_not(shift_or_not), .thumb_or_not(thumb_or_not),
        .imm32(imm32), .imm12(imm12), .s_type(s_type), .s_offset(s_offset),
        .index(index), .add(add), .wback(wback), .reg_mask(reg_mask)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, required finish before 200000");
        $fatal(1, "watchdog");
    end

    function automatic string fmt(input out_t o);
        return $sformatf("rd=%0d rd2=%0d ra=%0d rb=%0d ior=%0b sh=%0b th=%0b imm32=%h imm12=%h st=%0d so=%0d p=%0b u=%0b w=%0b rm=%0b",
                         o.rd, o.rd2, o.ra, o.rb, o.imm_or_reg, o.shift_or_not, o.thumb_or_not,
                         o.imm32, o.imm12, o.s_type, o.s_offset, o.index, o.add, o.wback, o.reg_mask);
    endfunction

    // Drive one instruction at the falling edge and record what must appear after the next rise.
    task automatic drive(input logic [31:0] i_inst, input logic i_rst, input out_t i_exp, input int i_id);
        sb_t s;
        @(negedge clk);
        inst     = i_inst;
        rst      = i_rst;
        carry_in = 1'($urandom_range(0, 1));
        s.exp    = i_exp;
        s.id     = i_id;
        sb_q.push_back(s);
    endtask

    // Monitor: one expected entry per rising edge, compared just after the edge.
    always @(posedge clk) begin
        sb_t  s;
        out_t act;
        #1;
        if (sb_q.size() != 0) begin
            s   = sb_q.pop_front();
            act = '{rd: rd, rd2: rd2, ra: ra, rb: rb, imm_or_reg: imm_or_reg,
                    shift_or_not: shift_or_not, thumb_or_not: thumb_or_not,
                    imm32: imm32, imm12: imm12, s_type: s_type, s_offset: s_offset,
                    index: index, add: add, wback: wback, reg_mask: reg_mask};
            n_cmp++;
            if (act !== s.exp) begin
                n_bad++;
                $display("FAIL vec%0d: got [%s] required [%s]", s.id, fmt(act), fmt(s.exp));
            end
        end
    end

    initial begin
        zero_o   = '0;
        rst      = 1'b1;
        inst     = '0;
        carry_in = 1'b0;

        vecs[0]  = '{32'h41480000, '{rb: 4'd1, thumb_or_not: 1'b1, default: '0}};
        vecs[1]  = '{32'h41481234, '{rb: 4'd1, thumb_or_not: 1'b1, default: '0}};
        vecs[2]  = '{32'h00880000, '{rb: 4'd1, s_offset: 5'd2, shift_or_not: 1'b1, thumb_or_not: 1'b1, default: '0}};
        vecs[3]  = '{32'h1D510000, '{rd: 4'd1, ra: 4'd2, imm32: 32'd5, imm_or_reg: 1'b1, thumb_or_not: 1'b1, default: '0}};
        vecs[4]  = '{32'h1BE30000, '{rd: 4'd3, ra: 4'd4, rb: 4'd7, thumb_or_not: 1'b1, default: '0}};
        vecs[5]  = '{32'h25A70000, '{rd: 4'd5, ra: 4'd5, imm32: 32'hA7, imm_or_reg: 1'b1, thumb_or_not: 1'b1, default: '0}};
        vecs[6]  = '{32'h69710000, '{rd: 4'd1, ra: 4'd6, imm32: 32'h14, index: 1'b1, add: 1'b1, thumb_or_not: 1'b1, default: '0}};
        vecs[7]  = '{32'h77D30000, '{rd: 4'd3, ra: 4'd2, imm32: 32'h1F, index: 1'b1, add: 1'b1, thumb_or_not: 1'b1, default: '0}};
        vecs[8]  = '{32'hB5100000, '{ra: 4'd13, reg_mask: 1'b1, thumb_or_not: 1'b1, default: '0}};
        vecs[9]  = '{32'hBD100000, '{ra: 4'd13, reg_mask: 1'b1, thumb_or_not: 1'b1, default: '0}};
        vecs[10] = '{32'hB0810000, '{thumb_or_not: 1'b1, default: '0}};
        vecs[11] = '{32'hCB0F0000, '{ra: 4'd3, reg_mask: 1'b1, thumb_or_not: 1'b1, default: '0}};
        vecs[12] = '{32'hE0000000, '{thumb_or_not: 1'b1, default: '0}};
        vecs[13] = '{32'hF10110FF, '{ra: 4'd1, imm12: 12'h1FF, imm32: 32'h00FF00FF, imm_or_reg: 1'b1, default: '0}};
        vecs[14] = '{32'hF1000442, '{rd: 4'd4, imm12: 12'h042, imm32: 32'h00000042, imm_or_reg: 1'b1, default: '0}};
        vecs[15] = '{32'hF10021AB, '{rd: 4'd1, imm12: 12'h2AB, imm32: 32'hAB00AB00, imm_or_reg: 1'b1, default: '0}};
        vecs[16] = '{32'hF10033CD, '{rd: 4'd3, imm12: 12'h3CD, imm32: 32'hCDCDCDCD, imm_or_reg: 1'b1, default: '0}};
        vecs[17] = '{32'hF5037A55, '{ra: 4'd3, rd: 4'd10, imm12: 12'hF55, imm32: 32'h00000354, imm_or_reg: 1'b1, default: '0}};
        vecs[18] = '{32'hF1018000, '{default: '0}};
        vecs[19] = '{32'hEB0218D9, '{ra: 4'd2, rd: 4'd8, rb: 4'd9, s_type: 2'd1, s_offset: 5'd7, shift_or_not: 1'b1, default: '0}};
        vecs[20] = '{32'hF8D12004, '{rd: 4'd2, ra: 4'd1, imm12: 12'h004, imm32: 32'd4, index: 1'b1, add: 1'b1, default: '0}};
        vecs[21] = '{32'hF8512B04, '{rd: 4'd2, ra: 4'd1, imm32: 32'd4, add: 1'b1, wback: 1'b1, default: '0}};
        vecs[22] = '{32'hF8410000, '{default: '0}};
        vecs[23] = '{32'hE9704502, '{rd: 4'd4, rd2: 4'd5, imm32: 32'd8, index: 1'b1, wback: 1'b1, default: '0}};
        vecs[24] = '{32'hE8B400F0, '{ra: 4'd4, reg_mask: 1'b1, wback: 1'b1, default: '0}};
        vecs[25] = '{32'hFB000000, '{default: '0}};

        // Reset state: decodable instruction held under reset must still give zeros.
        drive(32'h41480000, 1'b1, zero_o, 100);
        drive(32'hF10110FF, 1'b1, zero_o, 101);

        // Back-to-back table vectors, one per cycle.
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].inst, 1'b0, vecs[i].exp, i);
        end

        // Single-cycle reset pulse with ADC on the input, then decode resumes.
        drive(32'h41480000, 1'b0, vecs[0].exp, 200);
        drive(32'h41480000, 1'b1, zero_o, 201);
        drive(32'h41480000, 1'b0, vecs[0].exp, 202);

        // Reset in the middle of a 32-bit stream, released straight into LDRD.
        drive(32'hF8D12004, 1'b0, vecs[20].exp, 203);
        drive(32'hF8512B04, 1'b1, zero_o, 204);
        drive(32'hE9704502, 1'b0, vecs[23].exp, 205);
        drive(32'h00880000, 1'b0, vecs[2].exp, 206);

        // Drain the scoreboard within a bounded number of cycles.
        for (int k = 0; k < 8 && sb_q.size() != 0; k++) @(posedge clk);
        #2;
        if (sb_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending entries, required 0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/inst_pattern_match.md
INST_PATTERN_MATCH -- requirements
Module: inst_pattern_match

Interface
REQ-001 SHALL provide ports: clk, input, 1, sole clock; all outputs registered on rising edge.
REQ-002 SHALL provide rst, input, 1, synchronous active-high reset.
REQ-003 SHALL provide inst, input, 32, instruction word; 16-bit Thumb occupies inst[31:16], inst[15:0] ignored.
REQ-004 SHALL provide carry_in, input, 1, APSR.C; reserved, no effect on any output.
REQ-005 SHALL provide outputs rd, rd2, ra, rb, each 4 bits: Rd/Rt, Rt2, Rn, Rm.
REQ-006 SHALL provide imm_or_reg, output, 1: 1 = second operand immediate, 0 = register.
REQ-007 SHALL provide shift_or_not, output, 1: 1 = Rm shifted by s_type/s_offset.
REQ-008 SHALL provide thumb_or_not, output, 1: 1 = 16-bit encoding, 0 = 32-bit.
REQ-009 SHALL provide imm32, output, 32, expanded immediate, and imm12, output, 12, raw 12-bit immediate field.
REQ-010 SHALL provide s_type, output, 2 (00 LSL, 01 LSR, 10 ASR, 11 ROR), and s_offset, output, 5, shift amount.
REQ-011 SHALL provide index, add, wback, each output, 1: P, U, W addressing bits.
REQ-012 SHALL provide reg_mask, output, 1: 1 = instruction carries a register list (LDM/STM/PUSH/POP).

Function
REQ-013 SHALL register all outputs with 1-cycle latency: inst sampled at edge N appears after edge N.
REQ-014 SHALL classify inst as 32-bit when inst[31:27] is 11101, 11110 or 11111; otherwise 16-bit.
REQ-015 SHALL drive every field the matched pattern does not use to 0; unmatched encodings drive all outputs to 0 except thumb_or_not.
REQ-016 16-bit shift-imm (h[15:13]=000, h[12:11]!=11): rd=h[2:0], rb=h[5:3], s_type=h[12:11], s_offset=h[10:6], shift_or_not=1.
REQ-017 16-bit add/sub (h[15:11]=00011): rd=h[2:0], ra=h[5:3]; h[10]=1 -> imm32=h[8:6], imm_or_reg=1; else rb=h[8:6].
REQ-018 16-bit MOV/CMP/ADD/SUB imm8 (h[15:13]=001): rd=ra=h[10:8], imm32=zero-extended h[7:0], imm_or_reg=1.
REQ-019 16-bit data-processing register (h[15:10]=010000): rd=ra=h[2:0], rb=h[5:3], imm_or_reg=0.
REQ-020 16-bit LDR/STR imm5 (h[15:13]=011): rd=h[2:0], ra=h[5:3], imm32=imm5<<2 when h[12]=0, imm5 when h[12]=1, index=1, add=1, wback=0.
REQ-021 16-bit PUSH/POP (h[15:12]=1011, h[10:9]=10) and LDM/STM (h[15:12]=1100): reg_mask=1, ra=13 for PUSH/POP else h[10:8].
REQ-022 32-bit DP modified-imm (hw1[15:11]=11110, hw1[9]=0, hw2[15]=0): ra=hw1[3:0], rd=hw2[11:8], imm12={hw1[10],hw2[14:12],hw2[7:0]}, imm32=ThumbExpandImm(imm12), imm_or_reg=1.
REQ-023 ThumbExpandImm: imm12[11:10]=00 -> pattern by imm12[9:8] (00: 000000XY, 01: 00XY00XY, 10: XY00XY00, 11: XYXYXYXY); else ror({1,imm12[6:0]}, imm12[11:7]).
REQ-024 32-bit DP shifted-reg (hw1[15:9]=1110101): ra=hw1[3:0], rd=hw2[11:8], rb=hw2[3:0], s_type=hw2[5:4], s_offset={hw2[14:12],hw2[7:6]}, shift_or_not=1.
REQ-025 32-bit LDR/STR imm12 (hw1[15:8]=11111000, hw1[7]=1): rd=hw2[15:12], ra=hw1[3:0], imm12=hw2[11:0], imm32=zero-extended, index=1, add=1, wback=0.
REQ-026 32-bit LDR/STR imm8 (hw1[15:8]=11111000, hw1[7]=0, hw2[11]=1): rd=hw2[15:12], ra=hw1[3:0], imm32=hw2[7:0], index=hw2[10], add=hw2[9], wback=hw2[8].
REQ-027 32-bit LDRD/STRD (hw1[15:9]=1110100, hw1[6]=1): rd=hw2[15:12], rd2=hw2[11:8], ra=hw1[3:0], imm32=hw2[7:0]<<2, index=hw1[8], add=hw1[7], wback=hw1[5].
REQ-028 32-bit LDM/STM (hw1[15:9]=1110100, hw1[6]=0): ra=hw1[3:0], reg_mask=1, wback=hw1[5].
REQ-029 Purely combinational decode ahead of the output register; no other state.

Reset
REQ-030 rst=1 at a rising edge SHALL force every output to 0 after that edge, overriding inst; decoding resumes at the first edge with rst=0.

Verification
REQ-031 inst=0x41480000 (ADC r0,r1) -> rd=0, ra=0, rb=1, thumb_or_not=1, imm_or_reg=0.
REQ-032 inst=0x00880000 (LSLS r0,r1,#2) -> rd=0, rb=1, s_type=0, s_offset=2, shift_or_not=1.
REQ-033 inst=0xF10110FF (ADD.W r0,r1,#imm) -> rd=0, ra=1, imm12=0x1FF, imm32=0x00FF00FF, imm_or_reg=1, thumb_or_not=0.
REQ-034 inst=0xF8D12004 (LDR.W r2,[r1,#4]) -> rd=2, ra=1, imm12=0x004, imm32=4, index=1, add=1, wback=0.
REQ-035 inst=0xF8512B04 (LDR r2,[r1],#4) -> rd=2, ra=1, imm32=4, index=0, add=1, wback=1.
REQ-036 rst asserted one cycle while inst=0x41480000 -> all outputs 0 after that edge; correct decode one edge after release.
